irq_ctrl7: RTL and testbench
============================

IRQ_CTRL7 -- requirements
Module: irq_ctrl7

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: number of cycles int_req may stay unacknowledged before withdrawal (legal range 1..255).
REQ-002 SHALL have port c, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port r, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port irq, input, [7:1], raw interrupt request lines; bit 1 has highest priority.
REQ-005 SHALL have port ien_we, input, 1, write strobe for the interrupt-enable register.
REQ-006 SHALL have port ien_d, input, [7:1], enable data; 1 = line enabled.
REQ-007 SHALL have port int_ack, input, 1, CPU acknowledge, single-cycle pulse.
REQ-008 SHALL have port eoi, input, 1, CPU end-of-interrupt, single-cycle pulse.
REQ-009 SHALL have port int_req, output, 1, interrupt request to CPU.
REQ-010 SHALL have port int_id, output, [2:0], number of the requesting line; 0 = none.
REQ-011 SHALL have port in_svc, output, 1, high while an acknowledged interrupt is being serviced.
REQ-012 SHALL have port pending, output, [7:1], pending register, readable.
REQ-013 SHALL have port tmo, output, 1, one-cycle pulse on acknowledge timeout.

Function
REQ-014 SHALL register irq into irq_q every cycle.
REQ-015 SHALL capture a request: pending[i] set at the edge where irq[i]=1 (and irq_q[i]=0 when IRQ_EDGE_EN is defined).
REQ-016 SHALL give set priority over clear when pending[i] is set and cleared in the same cycle.
REQ-017 SHALL load ien from ien_d at the edge where ien_we=1; pending bits SHALL capture regardless of ien.
REQ-018 SHALL implement FSM states IDLE, REQ, SERV.
REQ-019 In IDLE, at any edge where (pending & ien) != 0, SHALL latch int_id = lowest-numbered set bit and enter REQ; int_req=1 from that edge.
REQ-020 In REQ, int_id SHALL stay frozen; changes to ien, pending or irq SHALL NOT alter it.
REQ-021 In REQ with int_ack=1, SHALL clear pending[int_id], set in_svc=1, deassert int_req, and enter SERV at the same edge.
REQ-022 In REQ, SHALL count cycles with int_ack=0; when the count reaches TIMEOUT, SHALL deassert int_req, pulse tmo for one cycle, keep pending[int_id], and return to IDLE.
REQ-023 In SERV, int_id SHALL hold its value; new requests only accumulate in pending.
REQ-024 In SERV with eoi=1, SHALL clear in_svc, set int_id=0, and return to IDLE; re-arbitration occurs no earlier than the next edge.
REQ-025 SHALL ignore int_ack outside REQ and eoi outside SERV.
REQ-026 SHALL keep the timeout counter at 0 outside REQ; it SHALL not wrap.
REQ-027 Minimum latency from an irq capture edge to int_req=1 SHALL be one clock.

Reset
REQ-028 With r=1 at an edge, SHALL set FSM=IDLE, int_req=0, int_id=0, in_svc=0, tmo=0, pending=0, ien=0, irq_q=0, counter=0; r overrides all other inputs.
REQ-029 Reset asserted mid-REQ or mid-SERV SHALL abandon the transaction with no tmo pulse.

Configuration
REQ-030 With IRQ_EDGE_EN defined, SHALL use rising-edge capture (irq & ~irq_q); without it, SHALL use level capture (irq[i]=1 sets pending[i] each cycle). In level mode a line held high re-pends immediately after ack.

Verification
REQ-031 Reset, then ien=7'h7F, irq=7'b0010100 (lines 3,5) -> int_req=1 with int_id=3 after one clock; ack -> pending=7'b0010000, in_svc=1.
REQ-032 SERV on id 3, eoi -> IDLE, then next edge int_req=1, int_id=5.
REQ-033 TIMEOUT=4, request line 7, no ack -> int_req drops after 4 REQ cycles, tmo pulses once, pending[7] remains 1, int_req re-asserts on the following edge.
REQ-034 Line 2 pending with ien[2]=0 -> no int_req; write ien=7'h02 -> int_req=1, int_id=2 one edge after the write.
REQ-035 In REQ with int_id=4, raise irq[1] -> int_id stays 4; pending[1] is set, and line 1 is served after eoi.
REQ-036 Edge mode: hold irq[6]=1 across ack and eoi -> no second request; level mode: the same stimulus produces a second int_req with int_id=6.

Source files
------------

// File: rtl/irq_ctrl7.sv
// Seven-line priority interrupt controller: request, acknowledge, service and
// acknowledge-timeout tracking. Define IRQ_EDGE_EN for rising-edge capture (default is level).
module irq_ctrl7 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       c,
  input  logic       r,
  input  logic [7:1] irq,
  input  logic       ien_we,
  input  logic [7:1] ien_d,
  input  logic       int_ack,
  input  logic       eoi,
  output logic       int_req,
  output logic [2:0] int_id,
  output logic       in_svc,
  output logic [7:1] pending,
  output logic       tmo
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t        state, state_n;
  logic [7:1]    irq_q, ien, set_mask, clr_mask, pend_en;
  logic [2:0]    first_id, id_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          int_req_n, in_svc_n, tmo_n, expire;

`ifdef IRQ_EDGE_EN
  assign set_mask = irq & ~irq_q;
`else
  assign set_mask = irq;
`endif

  assign pend_en = pending & ien;
  assign expire  = (cnt == CNT_LAST) && !int_ack;

  // Lowest-numbered enabled pending line wins
  always_comb begin
    first_id = '0;
    for (int i = 7; i >= 1; i--) begin
      if (pend_en[i]) first_id = 3'(i);
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      state   <= IDLE;
      irq_q   <= '0;
      ien     <= '0;
      pending <= '0;
      cnt     <= '0;
      int_req <= 1'b0;
      int_id  <= '0;
      in_svc  <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      state   <= state_n;
      irq_q   <= irq;
      if (ien_we) ien <= ien_d;
      // A new capture wins over an acknowledge clear of the same line
      pending <= (pending & ~clr_mask) | set_mask;
      cnt     <= cnt_n;
      int_req <= int_req_n;
      int_id  <= id_n;
      in_svc  <= in_svc_n;
      tmo     <= tmo_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|pend_en) state_n = REQ;
      REQ: begin
        if (int_ack)     state_n = SERV;
        else if (expire) state_n = IDLE;
      end
      SERV:    if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    int_req_n = 1'b0;
    in_svc_n  = 1'b0;
    tmo_n     = 1'b0;
    id_n      = int_id;
    cnt_n     = '0;
    clr_mask  = '0;
    case (state)
      IDLE: begin
        if (|pend_en) begin
          int_req_n = 1'b1;
          id_n      = first_id;
        end
      end
      REQ: begin
        if (int_ack) begin
          in_svc_n = 1'b1;
          for (int i = 1; i <= 7; i++) clr_mask[i] = (int_id == 3'(i));
        end else if (expire) begin
          tmo_n = 1'b1;
          id_n  = '0;
        end else begin
          int_req_n = 1'b1;
          cnt_n     = cnt + CW'(1);
        end
      end
      SERV: begin
        if (eoi) id_n = '0;
        else     in_svc_n = 1'b1;
      end
      default: id_n = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl7.sv
// Bench for irq_ctrl7: directed scenarios plus random traffic, every cycle's
// outputs checked against a behavioural model through a scoreboard queue.
module tb_irq_ctrl7;

  localparam int TMO = 4;

  logic       c = 1'b0;
  logic       r, ien_we, int_ack, eoi;
  logic [7:1] irq, ien_d;
  logic       int_req, in_svc, tmo;
  logic [2:0] int_id;
  logic [7:1] pending;

  int tests = 0;
  int fails = 0;

  // {int_req, int_id, in_svc, pending, tmo}
  logic [12:0] sb[$];

  irq_ctrl7 #(.TIMEOUT(TMO)) dut (
    .c(c), .r(r), .irq(irq), .ien_we(ien_we), .ien_d(ien_d),
    .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id),
    .in_svc(in_svc), .pending(pending), .tmo(tmo)
  );

  always #5 c = ~c;

  // Reference model: phase 0 = nothing outstanding, 1 = waiting for CPU ack, 2 = being serviced
  int         m_phase = 0;
  int         m_id = 0;
  int         m_waited = 0;
  bit         m_tmo = 0;
  bit [7:0]   m_pend = 0;
  bit [7:0]   m_ien = 0;
  bit [7:0]   m_prev = 0;

  task automatic model_step();
    bit [7:0] lines, newly;
    int pick;
    lines = {irq, 1'b0};
    if (r) begin
      m_phase = 0; m_id = 0; m_waited = 0; m_tmo = 0;
      m_pend = 0; m_ien = 0; m_prev = 0;
      return;
    end
`ifdef IRQ_EDGE_EN
    newly = lines & ~m_prev;
`else
    newly = lines;
`endif
    m_tmo = 0;
    if (m_phase == 0) begin
      pick = 0;
      for (int k = 7; k >= 1; k--) if (m_pend[k] && m_ien[k]) pick = k;
      if (pick != 0) begin
        m_phase = 1; m_id = pick; m_waited = 0;
      end
    end else if (m_phase == 1) begin
      if (int_ack) begin
        m_pend[m_id] = 1'b0;
        m_phase = 2; m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_phase = 0; m_id = 0; m_tmo = 1; m_waited = 0;
        end
      end
    end else if (eoi) begin
      m_phase = 0; m_id = 0;
    end
    m_pend = m_pend | newly;
    m_pend[0] = 1'b0;
    if (ien_we) m_ien = {ien_d, 1'b0};
    m_prev = lines;
  endtask

  function automatic logic [12:0] model_out();
    return {m_phase == 1, 3'(m_id), m_phase == 2, m_pend[7:1], m_tmo};
  endfunction

  // One clock: apply inputs, let the model follow the edge, queue the expectation
  task automatic cyc(input logic [7:1] i_irq, input logic i_we, input logic [7:1] i_d,
                     input logic i_ack, input logic i_eoi, input logic i_r);
    irq = i_irq; ien_we = i_we; ien_d = i_d; int_ack = i_ack; eoi = i_eoi; r = i_r;
    @(posedge c);
    model_step();
    sb.push_back(model_out());
    #1;
  endtask

  task automatic idle_cyc(input logic [7:1] i_irq);
    cyc(i_irq, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge c) begin
    logic [12:0] exp, act;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      act = {int_req, int_id, in_svc, pending, tmo};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL scoreboard: got req=%0b id=%0d svc=%0b pend=%07b tmo=%0b expected req=%0b id=%0d svc=%0b pend=%07b tmo=%0b at %0t",
                 act[12], act[11:9], act[8], act[7:1], act[0],
                 exp[12], exp[11:9], exp[8], exp[7:1], exp[0], $time);
      end
    end
  end

  initial begin
    int budget;
    logic [7:1] rirq;
    // Reset then basic two-line arbitration
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_state", {int_req, int_id, in_svc, pending, tmo}, 0);
    cyc(7'h00, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0);
    idle_cyc(7'b0010100);
    chk("capture_no_req_yet", int_req, 0);
    idle_cyc(7'h00);
    chk("first_req", {int_req, int_id}, {1'b1, 3'd3});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    chk("ack_state", {int_req, in_svc, pending}, {1'b0, 1'b1, 7'b0010000});
    // End of service, then the next line is arbitrated one edge later
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    chk("eoi_idle", {int_req, int_id, in_svc}, 0);
    idle_cyc(7'h00);
    chk("second_req", {int_req, int_id}, {1'b1, 3'd5});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // Acknowledge timeout on line 7
    idle_cyc(7'b1000000);
    idle_cyc(7'h00);
    for (int k = 0; k < TMO - 1; k++) begin
      chk("tmo_req_held", {int_req, int_id, tmo}, {1'b1, 3'd7, 1'b0});
      idle_cyc(7'h00);
    end
    chk("tmo_req_held", {int_req, int_id, tmo}, {1'b1, 3'd7, 1'b0});
    idle_cyc(7'h00);
    chk("tmo_pulse", {int_req, tmo, pending[7]}, {1'b0, 1'b1, 1'b1});
    idle_cyc(7'h00);
    chk("tmo_rearm", {int_req, int_id, tmo}, {1'b1, 3'd7, 1'b0});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // Disabled line stays pending until enabled
    cyc(7'h00, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
    idle_cyc(7'b0000010);
    idle_cyc(7'h00);
    chk("masked_no_req", {int_req, pending[2]}, {1'b0, 1'b1});
    cyc(7'h00, 1'b1, 7'h02, 1'b0, 1'b0, 1'b0);
    chk("enable_write_edge", int_req, 0);
    idle_cyc(7'h00);
    chk("enabled_req", {int_req, int_id}, {1'b1, 3'd2});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    cyc(7'h00, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0);

    // Frozen id while a higher-priority line arrives
    idle_cyc(7'b0001000);
    idle_cyc(7'h00);
    idle_cyc(7'b0000001);
    chk("id_frozen", {int_req, int_id, pending[1]}, {1'b1, 3'd4, 1'b1});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    idle_cyc(7'h00);
    chk("line1_after_eoi", {int_req, int_id}, {1'b1, 3'd1});
    cyc(7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // Line 6 held high across ack and eoi
    idle_cyc(7'b0100000);
    idle_cyc(7'b0100000);
    chk("held_first_req", {int_req, int_id}, {1'b1, 3'd6});
    cyc(7'b0100000, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    cyc(7'b0100000, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    idle_cyc(7'b0100000);
`ifdef IRQ_EDGE_EN
    chk("held_no_second", int_req, 0);
`else
    chk("held_second_req", {int_req, int_id}, {1'b1, 3'd6});
`endif

    // Reset in the middle of a transaction, then random traffic
    cyc(7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("mid_reset", {int_req, int_id, in_svc, pending, tmo}, 0);
    cyc(7'h00, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 800; n++) begin
      for (int k = 1; k <= 7; k++) rirq[k] = ($urandom_range(0, 7) == 0);
      cyc(rirq,
          $urandom_range(0, 29) == 0, 7'($urandom),
          (m_phase == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0),
          (m_phase == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0),
          $urandom_range(0, 199) == 0);
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge c);
      budget++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
